// File: rtl/hex_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hex_scan_if                                                     |
// | Purpose  : Bundles the data/control inputs and the display-pin outputs of  |
// |            hex_scan_driver.                                                |
// | Signals  : load, value, dp, blank, lzs, bright  (master -> slave)          |
// |            hex_seg, hex_grid, pending, frame_done (slave -> master)        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface hex_scan_if #(
  parameter int N_DIGITS = 4
);
  logic                  load;
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   blank;
  logic                  lzs;
  logic [3:0]            bright;
  logic [7:0]            hex_seg;
  logic [N_DIGITS-1:0]   hex_grid;
  logic                  pending;
  logic                  frame_done;

  modport master (
    output load, value, dp, blank, lzs, bright,
    input  hex_seg, hex_grid, pending, frame_done
  );

  modport slave (
    input  load, value, dp, blank, lzs, bright,
    output hex_seg, hex_grid, pending, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/hex_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hex_scan_driver                                                 |
// | Purpose  : Time-multiplexed common-anode seven-segment driver with decimal |
// |            points, per-digit blanking, leading-zero suppression, dead time |
// |            between slots and frame-atomic updates via a shadow register.  |
// | Ports    : clk, reset_n (async, active low), bus (hex_scan_if.slave)       |
// | Options  : define HEX_SCAN_DIM_EN to enable brightness PWM from bright.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module hex_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int DIV_BITS    = 17,
  parameter int DEAD_CYCLES = 64
) (
  input wire        clk,
  input wire        reset_n,
  hex_scan_if.slave bus
);

  localparam int                  c_DIG_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [c_DIG_W-1:0]  c_LAST_DIG = c_DIG_W'(N_DIGITS - 1);
  localparam logic [DIV_BITS-1:0] c_DEAD     = DIV_BITS'(DEAD_CYCLES);

  logic [DIV_BITS-1:0]   r_cnt;
  logic [c_DIG_W-1:0]    r_dig;
  logic [4*N_DIGITS-1:0] r_pend_value, r_act_value;
  logic [N_DIGITS-1:0]   r_pend_dp, r_act_dp;
  logic [N_DIGITS-1:0]   r_pend_blank, r_act_blank;
  logic                  r_pending;
  logic [7:0]            r_seg;
  logic [N_DIGITS-1:0]   r_grid;
  logic                  r_frame_done;

  logic                  w_wrap, w_boundary, w_pwm, w_lit;
  logic [3:0]            w_nib;
  logic                  w_dp_cur, w_blank_cur, w_supp_cur, w_zero_run;
  logic [7:0]            w_seg_on;
  logic [N_DIGITS-1:0]   w_grid;

  function automatic logic [6:0] f_glyph(input logic [3:0] n);
    case (n)
      4'h0: f_glyph = 7'h3F;  4'h1: f_glyph = 7'h06;
      4'h2: f_glyph = 7'h5B;  4'h3: f_glyph = 7'h4F;
      4'h4: f_glyph = 7'h66;  4'h5: f_glyph = 7'h6D;
      4'h6: f_glyph = 7'h7D;  4'h7: f_glyph = 7'h07;
      4'h8: f_glyph = 7'h7F;  4'h9: f_glyph = 7'h6F;
      4'hA: f_glyph = 7'h77;  4'hB: f_glyph = 7'h7C;
      4'hC: f_glyph = 7'h39;  4'hD: f_glyph = 7'h5E;
      4'hE: f_glyph = 7'h79;  default: f_glyph = 7'h71;
    endcase
  endfunction

  assign w_wrap     = &r_cnt;
  assign w_boundary = w_wrap && (r_dig == c_LAST_DIG);

  // Slot counter and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_dig <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_BITS'(1);
      if (w_wrap) r_dig <= (r_dig == c_LAST_DIG) ? '0 : r_dig + c_DIG_W'(1);
    end
  end

  // Shadow/active registers. A load coinciding with the frame boundary bypasses
  // the shadow so it is not delayed by a whole extra frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pending    <= 1'b0;
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '1;
    end else if (w_boundary) begin
      if (bus.load) begin
        r_act_value <= bus.value;
        r_act_dp    <= bus.dp;
        r_act_blank <= bus.blank;
        r_pending   <= 1'b0;
      end else if (r_pending) begin
        r_act_value <= r_pend_value;
        r_act_dp    <= r_pend_dp;
        r_act_blank <= r_pend_blank;
        r_pending   <= 1'b0;
      end
    end else if (bus.load) begin
      r_pend_value <= bus.value;
      r_pend_dp    <= bus.dp;
      r_pend_blank <= bus.blank;
      r_pending    <= 1'b1;
    end
  end

  // Select the current digit; scanning from the top keeps a running "all zero
  // so far" flag that gives leading-zero suppression for free.
  always_comb begin
    w_nib       = 4'h0;
    w_dp_cur    = 1'b0;
    w_blank_cur = 1'b0;
    w_supp_cur  = 1'b0;
    w_zero_run  = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_act_value[4*i +: 4] == 4'h0);
      if (r_dig == c_DIG_W'(i)) begin
        w_nib       = r_act_value[4*i +: 4];
        w_dp_cur    = r_act_dp[i];
        w_blank_cur = r_act_blank[i];
        w_supp_cur  = bus.lzs && (i > 0) && w_zero_run;
      end
    end
  end

`ifdef HEX_SCAN_DIM_EN
  // Top nibble of the slot counter splits the slot into 16 brightness steps.
  assign w_pwm = (r_cnt[DIV_BITS-1 -: 4] <= bus.bright);
`else
  assign w_pwm = 1'b1;
  wire w_unused_bright = ^bus.bright;
`endif

  assign w_lit    = (r_cnt >= c_DEAD) && !w_blank_cur && w_pwm;
  assign w_seg_on = {w_dp_cur, w_supp_cur ? 7'h00 : f_glyph(w_nib)};

  always_comb begin
    w_grid = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      w_grid[i] = !(w_lit && (r_dig == c_DIG_W'(i)));
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg        <= 8'hFF;
      r_grid       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_lit ? ~w_seg_on : 8'hFF;
      r_grid       <= w_grid;
      r_frame_done <= w_boundary;
    end
  end

  assign bus.hex_seg    = r_seg;
  assign bus.hex_grid   = r_grid;
  assign bus.pending    = r_pending;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hex_scan_driver                                              |
// | Purpose  : Self-checking bench for hex_scan_driver (N_DIGITS=4,            |
// |            DIV_BITS=6, DEAD_CYCLES=2): table of display patterns plus      |
// |            hand-written reset, atomicity, boundary-load and dim sequences. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_hex_scan_driver;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc;
  int   total = 0;
  int   bad   = 0;

  hex_scan_if #(.N_DIGITS(4)) bus ();

  hex_scan_driver #(.N_DIGITS(4), .DIV_BITS(6), .DEAD_CYCLES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // After posedge k (k counted from reset release) the outputs reflect the
  // slot position of cycle k: cnt = k%64, dig = (k/64)%4.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= -1;
    else          cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lzs;
    logic [3:0][7:0] seg;   // expected pins per digit while lit
  } row_t;

  typedef struct {
    int         at;
    int         dig;
    logic [7:0] seg;
    logic [3:0] grid;
  } exp_t;

  row_t rows [7];
  exp_t sb [$];

  function automatic int at(int frame, int slot, int off);
    return 256*frame + 64*slot + off;
  endfunction

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  // Drive load so that it is sampled at posedge p.
  task automatic do_load(input int p, input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] b, input logic z);
    wait_cyc(p - 1);
    bus.load  = 1'b1;
    bus.value = v;
    bus.dp    = d;
    bus.blank = b;
    bus.lzs   = z;
    wait_cyc(p);
    bus.load  = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   f;
    int   n_old;

    rows[0] = '{16'h12AF, 4'b0010, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'h08, 8'h8E}};
    rows[1] = '{16'h0050, 4'b1000, 4'b0000, 1'b1, {8'h7F, 8'hFF, 8'h92, 8'hC0}};
    rows[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    rows[3] = '{16'h3456, 4'b1111, 4'b1010, 1'b0, {8'hFF, 8'h19, 8'hFF, 8'h02}};
    rows[4] = '{16'h789B, 4'b0000, 4'b0000, 1'b0, {8'hF8, 8'h80, 8'h90, 8'h83}};
    rows[5] = '{16'hCDE0, 4'b0000, 4'b0000, 1'b1, {8'hC6, 8'hA1, 8'h86, 8'hC0}};
    rows[6] = '{16'h0600, 4'b0100, 4'b0000, 1'b1, {8'hFF, 8'h02, 8'hC0, 8'hC0}};

    bus.load = 1'b0; bus.value = '0; bus.dp = '0; bus.blank = '0;
    bus.lzs  = 1'b0; bus.bright = 4'hF;

    // Reset state and first commit with nothing loaded
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg",     {8'h0, bus.hex_seg},  16'h00FF);
    chk("rst_grid",    {12'h0, bus.hex_grid}, 16'h000F);
    chk("rst_fd",      {15'h0, bus.frame_done}, 16'h0000);
    chk("rst_pending", {15'h0, bus.pending}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    wait_cyc(10);
    chk("idle_seg",  {8'h0, bus.hex_seg},  16'h00FF);
    chk("idle_grid", {12'h0, bus.hex_grid}, 16'h000F);
    wait_cyc(254);
    chk("fd_before", {15'h0, bus.frame_done}, 16'h0000);
    wait_cyc(255);
    chk("fd_first",  {15'h0, bus.frame_done}, 16'h0001);
    wait_cyc(256);
    chk("fd_after",  {15'h0, bus.frame_done}, 16'h0000);
    wait_cyc(at(1, 0, 30));
    chk("empty_grid", {12'h0, bus.hex_grid}, 16'h000F);

    // Table-driven display patterns: load mid-frame, verify the following frame
    for (int r = 0; r < 7; r++) begin
      f = 2*r + 2;
      do_load(at(f - 1, 0, 100), rows[r].value, rows[r].dp, rows[r].blank, rows[r].lzs);
      chk("pend_set", {15'h0, bus.pending}, 16'h0001);
      for (int d = 0; d < 4; d++) begin
        sb.push_back('{at(f, d, 1), d, 8'hFF, 4'hF});
        sb.push_back('{at(f, d, 30), d,
                       rows[r].blank[d] ? 8'hFF : rows[r].seg[d],
                       rows[r].blank[d] ? 4'hF : (4'hF ^ (4'h1 << d))});
      end
      wait_cyc(at(f, 0, 0));
      chk("pend_clr", {15'h0, bus.pending}, 16'h0000);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        wait_cyc(e.at);
        chk($sformatf("row%0d_d%0d_seg", r, e.dig),  {8'h0, bus.hex_seg},   {8'h0, e.seg});
        chk($sformatf("row%0d_d%0d_grid", r, e.dig), {12'h0, bus.hex_grid}, {12'h0, e.grid});
      end
    end

    // Atomicity: the first of two loads in one frame is never shown
    do_load(at(15, 0, 50),  16'h1111, 4'h0, 4'h0, 1'b0);
    do_load(at(15, 0, 150), 16'h2222, 4'h0, 4'h0, 1'b0);
    n_old = 0;
    for (int k = at(15, 0, 151); k < at(17, 0, 0); k++) begin
      wait_cyc(k);
      if (bus.hex_seg == 8'hF9) n_old++;
      if (k == at(15, 3, 0))  chk("atom_pend_hi", {15'h0, bus.pending}, 16'h0001);
      if (k == at(16, 0, 0))  chk("atom_pend_lo", {15'h0, bus.pending}, 16'h0000);
      if (k == at(16, 0, 30)) chk("atom_seg",  {8'h0, bus.hex_seg},   16'h00A4);
      if (k == at(16, 2, 30)) chk("atom_grid", {12'h0, bus.hex_grid}, 16'h000B);
    end
    chk("atom_never_1111", 16'(n_old), 16'h0000);

    // Load exactly on the boundary cycle: immediate commit, no pending
    wait_cyc(at(17, 3, 62));
    chk("bnd_old_seg", {8'h0, bus.hex_seg}, 16'h00A4);
    do_load(at(17, 3, 63), 16'h000F, 4'h0, 4'h0, 1'b0);
    chk("bnd_pending", {15'h0, bus.pending},    16'h0000);
    chk("bnd_fd",      {15'h0, bus.frame_done}, 16'h0001);
    wait_cyc(at(18, 0, 0));
    chk("bnd_fd_low",  {15'h0, bus.frame_done}, 16'h0000);
    chk("dead0_grid",  {12'h0, bus.hex_grid},   16'h000F);
    wait_cyc(at(18, 0, 1));
    chk("dead1_seg",   {8'h0, bus.hex_seg},     16'h00FF);
    chk("dead1_grid",  {12'h0, bus.hex_grid},   16'h000F);
    wait_cyc(at(18, 0, 2));
    chk("lit2_grid",   {12'h0, bus.hex_grid},   16'h000E);
    chk("lit2_seg",    {8'h0, bus.hex_seg},     16'h008E);
    wait_cyc(at(18, 0, 63));
    chk("lit63_grid",  {12'h0, bus.hex_grid},   16'h000E);
    wait_cyc(at(18, 1, 30));
    chk("bnd_d1_seg",  {8'h0, bus.hex_seg},     16'h00C0);

    // Reset mid-frame discards pending and active data
    do_load(at(18, 1, 40), 16'h8888, 4'h0, 4'h0, 1'b0);
    wait_cyc(at(18, 2, 10));
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_seg",  {8'h0, bus.hex_seg},    16'h00FF);
    chk("mid_rst_grid", {12'h0, bus.hex_grid},  16'h000F);
    chk("mid_rst_pend", {15'h0, bus.pending},   16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_cyc(at(0, 0, 30));
    chk("post_rst_grid0", {12'h0, bus.hex_grid}, 16'h000F);
    wait_cyc(at(0, 3, 63));
    chk("post_rst_fd",    {15'h0, bus.frame_done}, 16'h0001);
    wait_cyc(at(1, 0, 30));
    chk("post_rst_grid1", {12'h0, bus.hex_grid}, 16'h000F);
    chk("post_rst_seg1",  {8'h0, bus.hex_seg},   16'h00FF);

`ifdef HEX_SCAN_DIM_EN
    do_load(at(1, 3, 10), 16'h0000, 4'h0, 4'h0, 1'b0);
    bus.bright = 4'h1;
    wait_cyc(at(2, 0, 7));
    chk("dim1_lit_grid",  {12'h0, bus.hex_grid}, 16'h000E);
    wait_cyc(at(2, 0, 8));
    chk("dim1_dark_grid", {12'h0, bus.hex_grid}, 16'h000F);
    chk("dim1_dark_seg",  {8'h0, bus.hex_seg},   16'h00FF);
    bus.bright = 4'hF;
    wait_cyc(at(2, 1, 63));
    chk("dim15_grid",     {12'h0, bus.hex_grid}, 16'h000D);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
